// File: rtl/cmplx_mac.sv
// Pipelined fixed-point complex multiply-accumulate: a*b or a*conj(b), either
// bypassed per beat or summed over an in_last-delimited group with saturation.

module cmplx_mac_sat_add #(
  parameter int OW = 48
) (
  input  logic signed [OW-1:0] acc,
  input  logic signed [OW-1:0] p,
  output logic signed [OW-1:0] sum,
  output logic                 sat
);
  localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

  logic [OW:0] full;

  assign full = {acc[OW-1], acc} + {p[OW-1], p};

  // One guard bit is enough: the top two bits disagree only on overflow.
  always_comb begin
    sat = full[OW] ^ full[OW-1];
    sum = full[OW-1:0];
    if (sat) sum = full[OW] ? MIN_V : MAX_V;
  end
endmodule

module cmplx_mac #(
  parameter int DW = 18,
  parameter int OW = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 acc_en,
  input  logic                 conj_b,
  input  logic signed [DW-1:0] areal,
  input  logic signed [DW-1:0] aimag,
  input  logic signed [DW-1:0] breal,
  input  logic signed [DW-1:0] bimag,
  output logic                 out_valid,
  output logic signed [OW-1:0] creal,
  output logic signed [OW-1:0] cimag,
  output logic                 ovf
);
  localparam int STAGES = 4;
  localparam int PW     = 2 * DW;
  localparam int SW     = 2 * DW + 1;

  typedef struct packed {
    logic last;
    logic acc;
  } ctrl_t;

  logic [STAGES:1]          vld_pipe;
  ctrl_t [STAGES-1:1]       ctrl_pipe;
  logic [2:1]               conj_pipe;

  logic signed [DW-1:0]     s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [PW-1:0]     pp_rr, pp_ii, pp_ri, pp_ir;
  logic signed [SW-1:0]     s3_re, s3_im;

  logic [1:0][OW-1:0]       p_ext;
  logic [1:0][OW-1:0]       acc_q;
  logic [1:0][OW-1:0]       sum_sat;
  logic [1:0]               sat;
  logic                     sticky;

  // Control and valid pipeline; only bypass and group-closing beats emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      ctrl_pipe <= '0;
      conj_pipe <= '0;
    end else begin
      vld_pipe[STAGES-1:1] <= {vld_pipe[STAGES-2:1], in_valid};
      vld_pipe[STAGES]     <= vld_pipe[STAGES-1] &
                              (~ctrl_pipe[STAGES-1].acc | ctrl_pipe[STAGES-1].last);
      ctrl_pipe <= {ctrl_pipe[STAGES-2:1], ctrl_t'{last: in_last, acc: acc_en}};
      conj_pipe <= {conj_pipe[1], conj_b};
    end
  end

  // Datapath stages S1..S3 are free-running and qualified by vld_pipe.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_ar <= areal;
      s1_ai <= aimag;
      s1_br <= breal;
      s1_bi <= bimag;
    end
    pp_rr <= PW'(s1_ar) * PW'(s1_br);
    pp_ii <= PW'(s1_ai) * PW'(s1_bi);
    pp_ri <= PW'(s1_ar) * PW'(s1_bi);
    pp_ir <= PW'(s1_ai) * PW'(s1_br);
    if (conj_pipe[2]) begin
      s3_re <= SW'(pp_rr) + SW'(pp_ii);
      s3_im <= SW'(pp_ir) - SW'(pp_ri);
    end else begin
      s3_re <= SW'(pp_rr) - SW'(pp_ii);
      s3_im <= SW'(pp_ri) + SW'(pp_ir);
    end
  end

  assign p_ext[0] = OW'(s3_re);
  assign p_ext[1] = OW'(s3_im);

  for (genvar k = 0; k < 2; k++) begin : g_comp
    cmplx_mac_sat_add #(.OW(OW)) u_sat (
      .acc (acc_q[k]),
      .p   (p_ext[k]),
      .sum (sum_sat[k]),
      .sat (sat[k])
    );
  end

  // S4: bypass beats leave the accumulator untouched so an open group survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      creal  <= '0;
      cimag  <= '0;
      ovf    <= 1'b0;
      acc_q  <= '0;
      sticky <= 1'b0;
    end else if (vld_pipe[STAGES-1]) begin
      if (!ctrl_pipe[STAGES-1].acc) begin
        creal <= p_ext[0];
        cimag <= p_ext[1];
        ovf   <= 1'b0;
      end else if (ctrl_pipe[STAGES-1].last) begin
        creal  <= sum_sat[0];
        cimag  <= sum_sat[1];
        ovf    <= sticky | (|sat);
        acc_q  <= '0;
        sticky <= 1'b0;
      end else begin
        acc_q  <= sum_sat;
        sticky <= sticky | (|sat);
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_cmplx_mac.sv
// Directed bench for cmplx_mac: latency, conj/bypass, grouping, saturation, reset.

module tb_cmplx_mac;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // 18/48 instance
  logic v1, l1, ae1, cj1;
  logic signed [17:0] ar1, ai1, br1, bi1;
  logic ov1, of1;
  logic signed [47:0] cr1, ci1;

  // 8/17 instance for saturation
  logic v2, l2, ae2, cj2;
  logic signed [7:0] ar2, ai2, br2, bi2;
  logic ov2, of2;
  logic signed [16:0] cr2, ci2;

  cmplx_mac #(.DW(18), .OW(48)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_last(l1), .acc_en(ae1), .conj_b(cj1),
    .areal(ar1), .aimag(ai1), .breal(br1), .bimag(bi1),
    .out_valid(ov1), .creal(cr1), .cimag(ci1), .ovf(of1)
  );

  cmplx_mac #(.DW(8), .OW(17)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_last(l2), .acc_en(ae2), .conj_b(cj2),
    .areal(ar2), .aimag(ai2), .breal(br2), .bimag(bi2),
    .out_valid(ov2), .creal(cr2), .cimag(ci2), .ovf(of2)
  );

  typedef struct {
    longint re;
    longint im;
    bit     ovf;
    int     cyc;
  } res_t;

  res_t q1[$];
  res_t q2[$];

  always @(negedge clk) begin
    if (ov1) q1.push_back('{re: longint'(cr1), im: longint'(ci1), ovf: of1, cyc: cyc});
    if (ov2) q2.push_back('{re: longint'(cr2), im: longint'(ci2), ovf: of2, cyc: cyc});
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one beat at a negedge; returns after its capture edge.
  task automatic beat1(input bit last, input bit acc, input bit conj,
                       input int ar, input int ai, input int br, input int bi,
                       output int dc);
    dc = cyc;
    v1 = 1'b1; l1 = last; ae1 = acc; cj1 = conj;
    ar1 = 18'(ar); ai1 = 18'(ai); br1 = 18'(br); bi1 = 18'(bi);
    @(negedge clk);
    v1 = 1'b0; l1 = 1'b0; ae1 = 1'b0; cj1 = 1'b0;
  endtask

  task automatic beat2(input bit last, input bit acc,
                       input int ar, input int ai, input int br, input int bi);
    v2 = 1'b1; l2 = last; ae2 = acc; cj2 = 1'b0;
    ar2 = 8'(ar); ai2 = 8'(ai); br2 = 8'(br); bi2 = 8'(bi);
    @(negedge clk);
    v2 = 1'b0; l2 = 1'b0; ae2 = 1'b0;
  endtask

  initial begin
    int d0, d1, d2;
    rst = 1'b1;
    v1 = 0; l1 = 0; ae1 = 0; cj1 = 0; ar1 = 0; ai1 = 0; br1 = 0; bi1 = 0;
    v2 = 0; l2 = 0; ae2 = 0; cj2 = 0; ar2 = 0; ai2 = 0; br2 = 0; bi2 = 0;
    idle(2);
    chk("rst_ov1", longint'(ov1), 0);
    chk("rst_cr1", longint'(cr1), 0);
    chk("rst_ci1", longint'(ci1), 0);
    chk("rst_of1", longint'(of1), 0);
    chk("rst_ov2", longint'(ov2), 0);
    chk("rst_cr2", longint'(cr2), 0);
    rst = 1'b0;
    idle(1);

    // Bypass multiply (3+4i)(5-2i) = 23+14i, latency 4 edges
    beat1(0, 0, 0, 3, 4, 5, -2, d0);
    idle(2);
    chk("byp_early_valid", longint'(ov1), 0);
    idle(1);
    chk("byp_valid", longint'(ov1), 1);
    chk("byp_re", longint'(cr1), 23);
    chk("byp_im", longint'(ci1), 14);
    chk("byp_ovf", longint'(of1), 0);
    idle(1);
    chk("byp_pulse", longint'(ov1), 0);
    chk("byp_hold_re", longint'(cr1), 23);

    // Conjugate bypass (3+4i)(5+2i) = 7+26i
    beat1(0, 0, 1, 3, 4, 5, -2, d0);
    idle(3);
    chk("conj_valid", longint'(ov1), 1);
    chk("conj_re", longint'(cr1), 7);
    chk("conj_im", longint'(ci1), 26);

    // Accumulation with bubbles: 4 * (1+i)^2 = 8i, then 2*(3i) = 6i
    idle(3);
    q1.delete();
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    idle(2);
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    beat1(1, 1, 0, 1, 1, 1, 1, d0);
    beat1(1, 1, 0, 2, 0, 0, 3, d1);
    idle(6);
    chk("acc_count", longint'(q1.size()), 2);
    chk("acc_re", q1[0].re, 0);
    chk("acc_im", q1[0].im, 8);
    chk("acc_ovf", longint'(q1[0].ovf), 0);
    chk("acc_lat", longint'(q1[0].cyc), longint'(d0 + 4));
    chk("clr_re", q1[1].re, 0);
    chk("clr_im", q1[1].im, 6);
    chk("clr_lat", longint'(q1[1].cyc), longint'(d1 + 4));

    // Interleaved bypass inside an open group
    q1.delete();
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    beat1(0, 0, 0, 2, 0, 2, 0, d1);
    beat1(1, 1, 0, 1, 1, 1, 1, d2);
    idle(6);
    chk("intl_count", longint'(q1.size()), 2);
    chk("intl_byp_re", q1[0].re, 4);
    chk("intl_byp_im", q1[0].im, 0);
    chk("intl_byp_lat", longint'(q1[0].cyc), longint'(d1 + 4));
    chk("intl_grp_re", q1[1].re, 0);
    chk("intl_grp_im", q1[1].im, 4);
    chk("intl_grp_lat", longint'(q1[1].cyc), longint'(d2 + 4));

    // Saturation on the 8/17 instance: 4*16384 clamps to 65535
    q2.delete();
    beat2(0, 1, -128, 0, -128, 0);
    beat2(0, 1, -128, 0, -128, 0);
    beat2(0, 1, -128, 0, -128, 0);
    beat2(1, 1, -128, 0, -128, 0);
    beat2(1, 1, 1, 0, 1, 0);
    idle(6);
    chk("sat_count", longint'(q2.size()), 2);
    chk("sat_re", q2[0].re, 65535);
    chk("sat_im", q2[0].im, 0);
    chk("sat_ovf", longint'(q2[0].ovf), 1);
    chk("sat_next_re", q2[1].re, 1);
    chk("sat_next_im", q2[1].im, 0);
    chk("sat_next_ovf", longint'(q2[1].ovf), 0);

    // Reset mid-group, with a bypass beat presented during reset
    q1.delete();
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    beat1(0, 1, 0, 1, 1, 1, 1, d0);
    rst = 1'b1;
    v1 = 1'b1; l1 = 1'b0; ae1 = 1'b0; cj1 = 1'b0;
    ar1 = 18'(3); ai1 = 18'(4); br1 = 18'(5); bi1 = -18'sd2;
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    chk("mrst_ov", longint'(ov1), 0);
    chk("mrst_re", longint'(cr1), 0);
    chk("mrst_im", longint'(ci1), 0);
    chk("mrst_ovf", longint'(of1), 0);
    beat1(1, 1, 0, 1, 1, 1, 1, d0);
    idle(6);
    chk("mrst_count", longint'(q1.size()), 1);
    chk("mrst_out_re", q1[0].re, 0);
    chk("mrst_out_im", q1[0].im, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
